// File: rtl/uart_rx_pkg.sv
// Shared defaults, pointer-width helper and per-cycle operation struct for the UART receive FIFO.
package uart_rx_pkg;

    localparam int unsigned DATA_W_DEF     = 8;
    localparam int unsigned FIFO_DEPTH_DEF = 8;

    // Pointers carry one extra wrap bit beyond the storage index.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic push;
        logic pop;
        logic drop;
    } fifo_op_t;

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port, one asynchronous read port, no reset.
module uart_rx_fifo_mem #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO behind the UART receiver with sticky overflow.
// Define RX_FIFO_AFULL_EN to add the almost_full output (count >= AFULL_THRESH).
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DATA_W_DEF,
    parameter int unsigned DEPTH        = FIFO_DEPTH_DEF,
    parameter int unsigned AFULL_THRESH = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     rx_data,
    input  logic                      rx_valid,
    input  logic                      flush,
    input  logic                      rd_ready,
    output logic                      rd_valid,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic [ptr_w(DEPTH)-1:0]   count,
    output logic                      empty,
    output logic                      full,
    output logic                      overflow,
    input  logic                      ovf_clr
`ifdef RX_FIFO_AFULL_EN
    ,
    output logic                      almost_full
`endif
);

    localparam int unsigned PTR_W = ptr_w(DEPTH);
    localparam int unsigned AW    = PTR_W - 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_rx_fifo: DEPTH must be a power of two and at least 2");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH - 1) begin : g_bad_thresh
        $error("uart_rx_fifo: AFULL_THRESH must be in 1..DEPTH-1");
    end

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic                  overflow_q, overflow_d;
    logic [PTR_W-1:0]      count_c;
    logic                  empty_c;
    logic                  full_c;
    logic [DATA_WIDTH-1:0] mem_rdata;
    fifo_op_t              op_c;

    // Status is a pure function of the registered pointers.
    always_comb begin
        count_c = wr_ptr_q - rd_ptr_q;
        empty_c = (wr_ptr_q == rd_ptr_q);
        full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    end

    // Flush masks both sides; a pop frees the slot a push into a full FIFO needs.
    always_comb begin
        op_c      = '0;
        op_c.pop  = !empty_c && rd_ready && !flush;
        op_c.push = rx_valid && !flush && (!full_c || op_c.pop);
        op_c.drop = rx_valid && !flush && full_c && !op_c.pop;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (op_c.push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
        end else if (op_c.pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        // A new drop outranks a same-cycle clear.
        if (op_c.drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    uart_rx_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (op_c.push),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (rx_data),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (mem_rdata)
    );

    assign rd_valid = !empty_c;
    assign rd_data  = empty_c ? DATA_WIDTH'(0) : mem_rdata;
    assign count    = count_c;
    assign empty    = empty_c;
    assign full     = full_c;
    assign overflow = overflow_q;

`ifdef RX_FIFO_AFULL_EN
    assign almost_full = (count_c >= PTR_W'(AFULL_THRESH));
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized and directed bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AFT   = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          flush;
    logic          rd_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic [3:0]    count;
    logic          empty;
    logic          full;
    logic          overflow;
    logic          ovf_clr;
`ifdef RX_FIFO_AFULL_EN
    logic          almost_full;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] mq[$];
    bit            movf;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .DATA_WIDTH   (DW),
        .DEPTH        (DEPTH),
        .AFULL_THRESH (AFT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .flush    (flush),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
`ifdef RX_FIFO_AFULL_EN
        ,
        .almost_full (almost_full)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        int sz;
        sz = mq.size();
        check({tag, ".rd_valid"}, 32'(rd_valid), 32'(sz != 0));
        check({tag, ".rd_data"},  32'(rd_data),  (sz != 0) ? 32'(mq[0]) : 32'd0);
        check({tag, ".count"},    32'(count),    32'(sz));
        check({tag, ".empty"},    32'(empty),    32'(sz == 0));
        check({tag, ".full"},     32'(full),     32'(sz == DEPTH));
        check({tag, ".overflow"}, 32'(overflow), 32'(movf));
`ifdef RX_FIFO_AFULL_EN
        check({tag, ".almost_full"}, 32'(almost_full), 32'(sz >= AFT));
`endif
    endtask

    // Reference: flush empties the queue; otherwise pop the head, then append if room.
    task automatic model_edge(input bit v, input logic [DW-1:0] d, input bit rdy,
                              input bit fl, input bit clr);
        bit popped;
        bit dropped;
        popped  = 1'b0;
        dropped = 1'b0;
        if (fl) begin
            mq.delete();
        end else begin
            if (rdy && mq.size() > 0) begin
                void'(mq.pop_front());
                popped = 1'b1;
            end
            if (v) begin
                if (mq.size() < DEPTH) mq.push_back(d);
                else dropped = 1'b1;
            end
        end
        if (dropped) movf = 1'b1;
        else if (clr) movf = 1'b0;
    endtask

    task automatic step(input string tag, input bit v, input logic [DW-1:0] d,
                        input bit rdy, input bit fl, input bit clr);
        rx_valid = v;
        rx_data  = d;
        rd_ready = rdy;
        flush    = fl;
        ovf_clr  = clr;
        @(posedge clk);
        model_edge(v, d, rdy, fl, clr);
        #1;
        check_outputs(tag);
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (mq.size() > 0 && guard < 2 * DEPTH) begin
            step(tag, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            guard++;
        end
        check({tag, ".drained"}, 32'(mq.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] pat;
        rst = 1'b1; rx_valid = 1'b0; rx_data = '0; flush = 1'b0; rd_ready = 1'b0; ovf_clr = 1'b0;
        mq.delete();
        movf = 1'b0;
        #3;
        check_outputs("reset");
        #9 rst = 1'b0;

        // Single byte, 1-cycle show-ahead latency, then pop.
        step("a5_push", 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        check("a5_data", 32'(rd_data), 32'h0000_00A5);
        step("a5_pop", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("a5_count0", 32'(count), 32'd0);

        // Fill, overflow on 9th, drain in order, clear.
        for (int i = 1; i <= 8; i++) step("fill", 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        check("fill_full", 32'(full), 32'd1);
        step("ovf_drop", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        check("ovf_set", 32'(overflow), 32'd1);
        drain("ovf_drain");
        step("ovf_clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("ovf_cleared", 32'(overflow), 32'd0);

        // Push into full while popping: accepted, no overflow.
        for (int i = 0; i < 8; i++) step("fill2", 1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
        step("full_pp", 1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        check("full_pp_cnt", 32'(count), 32'd8);
        check("full_pp_ovf", 32'(overflow), 32'd0);
        drain("full_pp_drain");

        // Wrap with occupancy bounded at 3.
        pat = 8'h40;
        for (int i = 0; i < 3; i++) begin
            step("wrap_pre", 1'b1, pat, 1'b0, 1'b0, 1'b0);
            pat++;
        end
        for (int i = 0; i < 20; i++) begin
            step("wrap", 1'b1, pat, 1'b1, 1'b0, 1'b0);
            check("wrap_cnt_max", 32'(count <= 4'd3), 32'd1);
            pat++;
        end
        drain("wrap_drain");

        // Flush with same-cycle write, overflow set beforehand to prove it survives.
        for (int i = 0; i < 9; i++) step("pre_ovf", 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        drain("pre_ovf_drain");
        for (int i = 0; i < 5; i++) step("fl_fill", 1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
        step("flush", 1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
        check("flush_cnt", 32'(count), 32'd0);
        check("flush_ovf", 32'(overflow), 32'd1);
        step("post_flush", 1'b1, 8'h12, 1'b0, 1'b0, 1'b1);
        check("post_flush_data", 32'(rd_data), 32'h0000_0012);
        drain("post_flush_drain");

        // Almost-full threshold crossing.
        for (int i = 0; i < 6; i++) step("af_fill", 1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
        step("af_pop", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step("af_push", 1'b1, 8'h99, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-traffic, sampled before any clock edge.
        #2 rst = 1'b1;
        #1;
        mq.delete();
        movf = 1'b0;
        check_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;

        // Random traffic: low drain rate first to reach full, then high.
        for (int i = 0; i < 600; i++) begin
            bit v, rdy, fl, clr;
            v   = ($urandom_range(0, 99) < 60);
            rdy = ($urandom_range(0, 99) < ((i < 300) ? 30 : 70));
            fl  = ($urandom_range(0, 99) < 3);
            clr = ($urandom_range(0, 99) < 5);
            step("rand", v, 8'($urandom), rdy, fl, clr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
